// File: rtl/sample_fifo_ctrl.sv
// Single-clock sample FIFO with a registered read port, occupancy flags and an
// optional set of sticky error flags, compiled in with SAMPLE_FIFO_ERR_FLAGS_EN.
module sample_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_W-1:0]          dato_in_i,
    input  logic                       wr_en_i,
    input  logic                       ready_i,
    input  logic                       rd_en_i,
    input  logic                       flush_i,
    output logic [DATA_W-1:0]          dato_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o,
    output logic                       udf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LVL);
    localparam logic [LW-1:0] AE_L    = LW'(AE_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] dato_q, dato_d;
    logic              valid_q, valid_d;
    logic              wr_req, wr_acc, rd_acc;

    // Handshake: a write counts when wr_en_i and ready_i are both high on an
    // edge and there is room (or a read frees a slot on that same edge); a read
    // counts when rd_en_i is high and the FIFO is non-empty, and its sample
    // appears on dato_o with valid_o high right after that edge, for one cycle.
    assign full_o         = (level_q == DEPTH_L);
    assign empty_o        = (level_q == '0);
    assign almost_full_o  = (level_q >= AF_L);
    assign almost_empty_o = (level_q <= AE_L);
    assign level_o        = level_q;
    assign dato_o         = dato_q;
    assign valid_o        = valid_q;

    assign wr_req = wr_en_i & ready_i & ~flush_i;
    assign rd_acc = rd_en_i & ~flush_i & ~empty_o;
    assign wr_acc = wr_req & (~full_o | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dato_d   = '0;
        valid_d  = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dato_d   = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dato_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dato_q   <= dato_d;
            valid_q  <= valid_d;
        end
    end

    // Storage is deliberately left unreset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= dato_in_i;
    end

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_req && full_o && !rd_acc) ovf_q <= 1'b1;
            if (rd_en_i && empty_o)          udf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
// Directed bench for sample_fifo_ctrl at DEPTH=16: fill/overflow, drain,
// gated writes, underflow, full-rate streaming across wrap, flush and reset.
module tb_sample_fifo_ctrl;

    localparam int DW = 16;
    localparam int DP = 16;

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [DW-1:0] dato_in_i = '0;
    logic          wr_en_i = 1'b0, ready_i = 1'b0, rd_en_i = 1'b0, flush_i = 1'b0;
    logic [DW-1:0] dato_o;
    logic          valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
    logic [4:0]    level_o;
    logic          ovf_o, udf_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;

    sample_fifo_ctrl #(.DATA_W(DW), .DEPTH(DP), .AF_LVL(12), .AE_LVL(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .dato_in_i(dato_in_i), .wr_en_i(wr_en_i),
        .ready_i(ready_i), .rd_en_i(rd_en_i), .flush_i(flush_i), .dato_o(dato_o),
        .valid_o(valid_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .level_o(level_o), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #6 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i = 1'b0; ready_i = 1'b0; rd_en_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic check_read(input string tag);
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            exp_v = exp_q.pop_front();
            check_val({tag, "_data"}, 32'(dato_o), 32'(exp_v));
            check_val({tag, "_valid"}, 32'(valid_o), 32'd1);
        end
    endtask

    initial begin
        // Reset state
        #3;
        check_val("rst_level", 32'(level_o), 32'd0);
        check_val("rst_empty", 32'(empty_o), 32'd1);
        check_val("rst_ae", 32'(almost_empty_o), 32'd1);
        check_val("rst_full", 32'(full_o), 32'd0);
        check_val("rst_af", 32'(almost_full_o), 32'd0);
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_dato", 32'(dato_o), 32'd0);
        check_val("rst_ovf", 32'(ovf_o), 32'd0);
        check_val("rst_udf", 32'(udf_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fill 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            wr_en_i = 1'b1; ready_i = 1'b1; dato_in_i = DW'(i);
            exp_q.push_back(DW'(i));
            step();
            check_val("fill_level", 32'(level_o), 32'(i));
            check_val("fill_af", 32'(almost_full_o), (i >= 12) ? 32'd1 : 32'd0);
        end
        check_val("fill_full", 32'(full_o), 32'd1);
        check_val("fill_ovf_clear", 32'(ovf_o), 32'd0);

        // 17th write is refused
        dato_in_i = 16'h0011;
        step();
        check_val("ovf_level", 32'(level_o), 32'd16);
        check_val("ovf_flag", 32'(ovf_o), 32'(FLAGS_ON));
        idle();

        // Drain back-to-back
        for (int k = 1; k <= 16; k++) begin
            rd_en_i = 1'b1;
            step();
            check_read("drain");
            check_val("drain_level", 32'(level_o), 32'(16 - k));
            check_val("drain_ae", 32'(almost_empty_o), ((16 - k) <= 4) ? 32'd1 : 32'd0);
        end
        rd_en_i = 1'b0;
        step();
        check_val("drain_dato0", 32'(dato_o), 32'd0);
        check_val("drain_valid0", 32'(valid_o), 32'd0);
        check_val("drain_empty", 32'(empty_o), 32'd1);

        // Writes without ready_i are ignored
        for (int i = 0; i < 8; i++) begin
            wr_en_i = 1'b1; ready_i = 1'b0; dato_in_i = 16'hBEEF;
            step();
            check_val("noready_level", 32'(level_o), 32'd0);
        end

        // Read on empty, with a concurrent write: no fall-through
        wr_en_i = 1'b1; ready_i = 1'b1; rd_en_i = 1'b1; dato_in_i = 16'hAAAA;
        step();
        check_val("udf_flag", 32'(udf_o), 32'(FLAGS_ON));
        check_val("udf_valid", 32'(valid_o), 32'd0);
        check_val("udf_dato", 32'(dato_o), 32'd0);
        check_val("udf_level", 32'(level_o), 32'd1);
        idle();
        flush_i = 1'b1;
        step();
        check_val("flush1_level", 32'(level_o), 32'd0);
        check_val("flush1_ovf", 32'(ovf_o), 32'd0);
        check_val("flush1_udf", 32'(udf_o), 32'd0);
        idle();

        // Full, then 40 cycles of simultaneous read and write
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            wr_en_i = 1'b1; ready_i = 1'b1; dato_in_i = DW'(16'h0100 + i);
            exp_q.push_back(DW'(16'h0100 + i));
            step();
        end
        check_val("stream_full", 32'(full_o), 32'd1);
        for (int j = 0; j < 40; j++) begin
            wr_en_i = 1'b1; ready_i = 1'b1; rd_en_i = 1'b1;
            dato_in_i = DW'(16'h0200 + j);
            exp_q.push_back(DW'(16'h0200 + j));
            step();
            check_read("stream");
            check_val("stream_level", 32'(level_o), 32'd16);
            check_val("stream_ovf", 32'(ovf_o), 32'd0);
        end
        idle();

        // Drain to level 9, then flush with wr/rd also asserted
        for (int k = 0; k < 7; k++) begin
            rd_en_i = 1'b1;
            step();
            check_read("part");
        end
        check_val("part_level", 32'(level_o), 32'd9);
        flush_i = 1'b1; wr_en_i = 1'b1; ready_i = 1'b1; rd_en_i = 1'b1;
        step();
        check_val("flush2_level", 32'(level_o), 32'd0);
        check_val("flush2_valid", 32'(valid_o), 32'd0);
        check_val("flush2_dato", 32'(dato_o), 32'd0);
        check_val("flush2_empty", 32'(empty_o), 32'd1);
        check_val("flush2_ovf", 32'(ovf_o), 32'd0);
        check_val("flush2_udf", 32'(udf_o), 32'd0);
        idle();
        exp_q.delete();

        // After flush, order restarts from the new first write
        for (int i = 0; i < 3; i++) begin
            wr_en_i = 1'b1; ready_i = 1'b1; dato_in_i = DW'(16'h0C00 + i);
            exp_q.push_back(DW'(16'h0C00 + i));
            step();
        end
        wr_en_i = 1'b0; rd_en_i = 1'b1;
        step();
        check_read("postflush");
        check_val("postflush_level", 32'(level_o), 32'd2);

        // Asynchronous reset mid-stream, between edges
        wr_en_i = 1'b1; dato_in_i = 16'h5555;
        #2 rst_ni = 1'b0;
        #1;
        check_val("arst_level", 32'(level_o), 32'd0);
        check_val("arst_valid", 32'(valid_o), 32'd0);
        check_val("arst_dato", 32'(dato_o), 32'd0);
        check_val("arst_empty", 32'(empty_o), 32'd1);
        check_val("arst_ae", 32'(almost_empty_o), 32'd1);
        idle();
        #1 rst_ni = 1'b1;
        exp_q.delete();

        // Clean operation after reset
        wr_en_i = 1'b1; ready_i = 1'b1; dato_in_i = 16'h1234;
        exp_q.push_back(16'h1234);
        step();
        wr_en_i = 1'b0; rd_en_i = 1'b1;
        step();
        check_read("postrst");
        check_val("postrst_empty", 32'(empty_o), 32'd1);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sample_fifo_ctrl.md
SAMPLE_FIFO_CTRL -- requirements
Module: sample_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 1024, number of entries; power of two, at least 4.
REQ-003 Parameter AF_LVL, default DEPTH-4, level at or above which almost_full_o is asserted.
REQ-004 Parameter AE_LVL, default 4, level at or below which almost_empty_o is asserted.
REQ-005 Port clk_i, input, 1, single clock (78 MHz system clock); all logic is on the rising edge.
REQ-006 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 Port dato_in_i, input, DATA_W, write sample.
REQ-008 Port wr_en_i, input, 1, write request.
REQ-009 Port ready_i, input, 1, upstream qualifier; a write request counts only when ready_i=1.
REQ-010 Port rd_en_i, input, 1, read request.
REQ-011 Port flush_i, input, 1, synchronous clear of contents.
REQ-012 Port dato_o, output, DATA_W, registered read sample.
REQ-013 Port valid_o, output, 1, dato_o holds a sample popped on the previous edge.
REQ-014 Ports full_o, empty_o, almost_full_o and almost_empty_o are 1-bit outputs that report occupancy status.
REQ-015 Port level_o, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-016 Ports ovf_o and udf_o are 1-bit outputs that carry the sticky overflow and underflow flags.

Function
REQ-017 Storage is inferred inside the block as a DEPTH x DATA_W array; no vendor FIFO IP is used.
REQ-018 A write is accepted when wr_en_i=1, ready_i=1, flush_i=0, and either full_o=0 or a read is accepted in the same cycle.
REQ-019 A read is accepted when rd_en_i=1, flush_i=0 and empty_o=0; there is no fall-through, so a read while the FIFO is empty is not accepted even if a write occurs in the same cycle.
REQ-020 An accepted read loads dato_o with the oldest entry and sets valid_o=1 on the same edge (1-cycle latency); otherwise dato_o is 0 and valid_o is 0 on that edge.
REQ-021 Read and write pointers have log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap.
REQ-022 On each edge level_o increments by 1 on a write alone, decrements by 1 on a read alone, and is unchanged when both or neither occur.
REQ-023 full_o=(level_o==DEPTH), empty_o=(level_o==0), almost_full_o=(level_o>=AF_LVL), almost_empty_o=(level_o<=AE_LVL); all four are decoded from the registered level.
REQ-024 When the FIFO is full and reads and writes occur together, both are accepted and the level stays at DEPTH.
REQ-025 flush_i=1 has priority over all other inputs; on the next edge pointers, level_o, dato_o, valid_o, ovf_o and udf_o are all 0. Array contents are don't-care.
REQ-026 A write request with ready_i=1 that is refused because the FIFO is full does not modify the array or the pointers.

Reset
REQ-027 Assertion of rst_ni=0 immediately forces pointers, level_o, dato_o, valid_o, ovf_o and udf_o to 0; empty_o and almost_empty_o read 1, and full_o and almost_full_o read 0.
REQ-028 Reset asserted mid-transfer discards any in-flight read or write; no partial update survives.
REQ-029 Array contents are not reset.

Configuration
REQ-030 Macro SAMPLE_FIFO_ERR_FLAGS_EN controls whether the sticky error flags are compiled in.
REQ-031 With SAMPLE_FIFO_ERR_FLAGS_EN defined, ovf_o sets on the edge after a refused write (wr_en_i=1, ready_i=1, flush_i=0, full with no accepted read), udf_o sets on the edge after rd_en_i=1 with empty_o=1 and flush_i=0, and both flags hold until flush or reset.
REQ-032 Without SAMPLE_FIFO_ERR_FLAGS_EN, ovf_o and udf_o are constant 0 and their logic is absent; the port list is identical.

Verification
REQ-033 DEPTH=16, write 0x0001..0x0010 with ready_i=1 -> full_o=1, level_o=16, almost_full_o from level 12; 17th write -> level stays 16, ovf_o=1 (macro on).
REQ-034 Read 16 samples back-to-back -> dato_o=0x0001..0x0010 in order, one cycle after each rd_en_i, valid_o=1; afterwards dato_o=0, valid_o=0, empty_o=1.
REQ-035 wr_en_i=1 with ready_i=0 for 8 cycles -> level_o stays 0; then rd_en_i=1 on empty -> udf_o=1 (macro on) or udf_o=0 (macro off).
REQ-036 Full FIFO with simultaneous read and write for 40 cycles -> level_o=16 throughout, no ovf_o, output order preserved across pointer wrap.
REQ-037 Level 9 then flush_i=1 with wr_en_i=1 and rd_en_i=1 in the same cycle -> next edge level_o=0, valid_o=0, flags cleared; rst_ni pulsed low mid-stream -> outputs 0 with no clock edge.
